// File: rtl/udp_pkt_feeder.sv
// udp_pkt_feeder
//   Packetizer in front of the UDP transmit engine. Capture words are buffered
//   in a single-clock FIFO. A frame is started whenever a full packet is queued,
//   or when a frame-end flush is pending with residual words in the FIFO. The
//   block then answers the engine's word requests and waits for tx_done.
//
//   Optional feature macro: UDP_PKT_HDR_EN
//     When defined, every packet is prefixed with {8'hA5, frame_cnt, pkt_seq}.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   wr_en, wr_data       capture word write strobe and data
//   frame_start          pulse: clear pkt_seq, bump frame_cnt
//   frame_end            pulse: flush residual words as a short packet
//   fifo_full, ovf       FIFO full flag, sticky dropped-write flag
//   tx_start_en          one-cycle start pulse to the engine
//   tx_byte_num          payload bytes of the current packet
//   tx_req, tx_data      engine word request, registered word answer
//   tx_done              engine finished the frame
module udp_pkt_feeder #(
  parameter int unsigned PKT_WORDS  = 256,
  parameter int unsigned FIFO_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        frame_start,
  input  logic        frame_end,
  output logic        fifo_full,
  output logic        ovf,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  input  logic        tx_req,
  output logic [31:0] tx_data,
  input  logic        tx_done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] PKT_LVL  = LW'(PKT_WORDS);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

`ifdef UDP_PKT_HDR_EN
  localparam int unsigned HDR_WORDS = 1;
`else
  localparam int unsigned HDR_WORDS = 0;
`endif

  typedef enum logic [1:0] {IDLE, START, SEND, WAIT_DONE} state_t;

  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_ovf;

  state_t        r_state;
  logic          r_start_en;
  logic [15:0]   r_byte_num;
  logic [15:0]   r_word_cnt;
  logic [15:0]   r_last_cnt;   // n_words + header words of the current packet
  logic [31:0]   r_tx_data;
  logic          r_flush_pend;
  logic [7:0]    r_frame_cnt;
  logic [15:0]   r_pkt_seq;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_hdr_slot;
  logic [31:0]   w_hdr_word;
  logic [15:0]   w_flush_cnt;

  assign w_full      = (r_level == FULL_LVL);
  assign w_push      = wr_en && !w_full;
  assign w_pop       = (r_state == SEND) && tx_req && !w_hdr_slot;
  assign w_flush_cnt = 16'(r_level) + 16'(HDR_WORDS);

  assign fifo_full   = w_full;
  assign ovf         = r_ovf;
  assign tx_start_en = r_start_en;
  assign tx_byte_num = r_byte_num;
  assign tx_data     = r_tx_data;

`ifdef UDP_PKT_HDR_EN
  logic [31:0] r_hdr;

  // Header is captured while idle so it carries the pkt_seq value from
  // before the increment that accompanies the start pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hdr <= '0;
    end else if (r_state == IDLE) begin
      r_hdr <= {8'hA5, r_frame_cnt, r_pkt_seq};
    end
  end

  assign w_hdr_word = r_hdr;
  assign w_hdr_slot = (r_word_cnt == '0);
`else
  logic w_unused_cnt;

  assign w_hdr_word   = '0;
  assign w_hdr_slot   = 1'b0;
  assign w_unused_cnt = ^{r_frame_cnt, r_pkt_seq};
`endif

  // FIFO storage, no reset needed on the array itself.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (wr_en && w_full) begin
        r_ovf <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_start_en   <= 1'b0;
      r_byte_num   <= '0;
      r_word_cnt   <= '0;
      r_last_cnt   <= '0;
      r_tx_data    <= '0;
      r_flush_pend <= 1'b0;
      r_frame_cnt  <= '0;
      r_pkt_seq    <= '0;
    end else begin
      r_start_en <= 1'b0;

      if (frame_start) begin
        r_pkt_seq   <= '0;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end else if (r_state == START) begin
        r_pkt_seq <= r_pkt_seq + 16'd1;
      end

      // A new frame_end always wins over a coincident clear.
      if (frame_end) begin
        r_flush_pend <= 1'b1;
      end else if ((r_state == WAIT_DONE) && tx_done && (r_level == '0)) begin
        r_flush_pend <= 1'b0;
      end else if ((r_state == IDLE) && (r_level == '0)) begin
        r_flush_pend <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          r_word_cnt <= '0;
          if (r_level >= PKT_LVL) begin
            r_last_cnt <= 16'(PKT_WORDS + HDR_WORDS);
            r_byte_num <= 16'((PKT_WORDS + HDR_WORDS) * 4);
            r_start_en <= 1'b1;
            r_state    <= START;
          end else if (r_flush_pend && (r_level != '0)) begin
            r_last_cnt <= w_flush_cnt;
            r_byte_num <= w_flush_cnt << 2;
            r_start_en <= 1'b1;
            r_state    <= START;
          end
        end
        START: begin
          r_state <= SEND;
        end
        SEND: begin
          if (tx_req) begin
            r_tx_data  <= w_hdr_slot ? w_hdr_word : r_mem[r_rd_ptr];
            r_word_cnt <= r_word_cnt + 16'd1;
            if ((r_word_cnt + 16'd1) == r_last_cnt) begin
              r_state <= WAIT_DONE;
            end
          end
        end
        WAIT_DONE: begin
          if (tx_done) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_pkt_feeder.sv
// Testbench for udp_pkt_feeder: small packet/FIFO sizes, a queue-based model
// of the FIFO contents and a behavioural engine that requests words with
// random gaps. Works with or without UDP_PKT_HDR_EN defined.
module tb_udp_pkt_feeder;

  localparam int unsigned PKT   = 4;
  localparam int unsigned DEPTH = 16;

`ifdef UDP_PKT_HDR_EN
  localparam int unsigned HDR = 1;
`else
  localparam int unsigned HDR = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        frame_start = 1'b0;
  logic        frame_end = 1'b0;
  logic        fifo_full;
  logic        ovf;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic        tx_req = 1'b0;
  logic [31:0] tx_data;
  logic        tx_done = 1'b0;

  udp_pkt_feeder #(
    .PKT_WORDS  (PKT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .fifo_full   (fifo_full),
    .ovf         (ovf),
    .tx_start_en (tx_start_en),
    .tx_byte_num (tx_byte_num),
    .tx_req      (tx_req),
    .tx_data     (tx_data),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Model state: words expected in the FIFO, header counters.
  logic [31:0] mq[$];
  logic [7:0]  m_frame = '0;
  logic [15:0] m_seq = '0;

  // Start pulse monitor.
  int unsigned start_cnt = 0;
  int unsigned starts_seen = 0;
  int unsigned gap_viol = 0;
  int unsigned cyc = 0;
  int unsigned last_start = 0;
  bit          have_start = 1'b0;
  logic [15:0] start_bytes = '0;

  always @(negedge clk) begin
    cyc++;
    if (tx_start_en === 1'b1) begin
      if (have_start && (cyc - last_start < 4)) gap_viol++;
      have_start  = 1'b1;
      last_start  = cyc;
      start_cnt++;
      start_bytes = tx_byte_num;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] w, input bit fe);
    wr_en     = 1'b1;
    wr_data   = w;
    frame_end = fe;
    if (mq.size() < DEPTH) mq.push_back(w);
    tick();
    wr_en     = 1'b0;
    frame_end = 1'b0;
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    m_seq   = '0;
    m_frame = m_frame + 8'd1;
  endtask

  task automatic expect_no_start(input string tag, input int unsigned cycles);
    int unsigned s;
    s = start_cnt;
    repeat (cycles) tick();
    check_eq(tag, start_cnt - s, 0);
  endtask

  // Wait for a start pulse (bounded); returns 0 on timeout.
  task automatic wait_start(output bit ok);
    int unsigned to;
    to = 0;
    while (start_cnt == starts_seen && to < 400) begin
      tick();
      to++;
    end
    ok = (start_cnt != starts_seen);
    if (!ok) check_eq("start_timeout", 32'd0, 32'd1);
    else starts_seen++;
  endtask

  // Behavioural engine for one packet.
  task automatic run_packet(input int unsigned done_dly, input bit fe_mid);
    bit          ok;
    int unsigned n, tot, gap, s;
    logic [31:0] hdr, exp;
    wait_start(ok);
    if (!ok) return;
    n   = (mq.size() >= PKT) ? PKT : mq.size();
    tot = n + HDR;
    check_eq("byte_num", 32'(start_bytes), 32'(4 * tot));
    hdr   = {8'hA5, m_frame, m_seq};
    m_seq = m_seq + 16'd1;
    exp   = '0;
    for (int unsigned i = 0; i < tot; i++) begin
      gap = (i == 0) ? $urandom_range(1, 3) : $urandom_range(0, 2);
      repeat (gap) tick();
      tx_req = 1'b1;
      if (fe_mid && i == 0) frame_end = 1'b1;
      exp = (HDR == 1 && i == 0) ? hdr : mq.pop_front();
      tick();
      tx_req    = 1'b0;
      frame_end = 1'b0;
      check_eq("tx_data", tx_data, exp);
    end
    check_eq("byte_num_hold", 32'(tx_byte_num), 32'(4 * tot));
    // Requests after the last word must be ignored.
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
    check_eq("wait_hold", tx_data, exp);
    s = start_cnt;
    repeat (done_dly) tick();
    check_eq("no_early_start", start_cnt - s, 0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    bit          ok;
    logic [31:0] hdr, exp;

    repeat (3) tick();
    check_eq("rst_start_en", 32'(tx_start_en), 32'd0);
    check_eq("rst_byte_num", 32'(tx_byte_num), 32'd0);
    check_eq("rst_tx_data",  tx_data,          32'd0);
    check_eq("rst_ovf",      32'(ovf),         32'd0);
    check_eq("rst_full",     32'(fifo_full),   32'd0);
    rst_n = 1'b1;
    tick();

    // Full packet of known words.
    for (int unsigned i = 1; i <= PKT; i++) write_word(32'(i), 1'b0);
    run_packet(4, 1'b0);
    expect_no_start("idle_after_full", 20);

    // Short flush, frame_end coincident with the last write.
    for (int unsigned i = 0; i < 3; i++) write_word($urandom, (i == 2));
    run_packet(3, 1'b0);
    expect_no_start("flush_cleared", 20);

    // frame_end with an empty FIFO starts nothing.
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    expect_no_start("flush_empty", 20);

    // frame_end during SEND is serviced from the next IDLE.
    for (int unsigned i = 0; i < PKT + 2; i++) write_word($urandom, 1'b0);
    run_packet(2, 1'b1);
    run_packet(2, 1'b0);
    expect_no_start("flush_mid_done", 20);

    // Continuous writes, engine holds tx_done off for 100 cycles.
    pulse_frame_start();
    fork
      begin
        for (int unsigned i = 0; i < 3 * PKT; i++) write_word($urandom, 1'b0);
      end
      begin
        for (int unsigned k = 0; k < 3; k++) run_packet(100, 1'b0);
      end
    join
    pulse_frame_start();
    for (int unsigned i = 0; i < PKT; i++) write_word($urandom, 1'b0);
    run_packet(5, 1'b0);

    // Overflow: fill to depth while the engine stalls, then one more write.
    for (int unsigned i = 0; i < DEPTH; i++) write_word($urandom, 1'b0);
    check_eq("full_set",   32'(fifo_full), 32'd1);
    check_eq("ovf_clear",  32'(ovf),       32'd0);
    write_word(32'hDEAD_BEEF, 1'b0);
    check_eq("full_hold",  32'(fifo_full), 32'd1);
    check_eq("ovf_set",    32'(ovf),       32'd1);
    for (int unsigned k = 0; k < DEPTH / PKT; k++) run_packet(3, 1'b0);
    check_eq("ovf_sticky", 32'(ovf),       32'd1);
    check_eq("full_clear", 32'(fifo_full), 32'd0);
    expect_no_start("drained", 20);

    // Reset in the middle of SEND after two requests.
    for (int unsigned i = 0; i < PKT; i++) write_word($urandom, 1'b0);
    wait_start(ok);
    if (ok) begin
      hdr   = {8'hA5, m_frame, m_seq};
      m_seq = m_seq + 16'd1;
      for (int unsigned i = 0; i < 2; i++) begin
        tick();
        tx_req = 1'b1;
        exp = (HDR == 1 && i == 0) ? hdr : mq.pop_front();
        tick();
        tx_req = 1'b0;
        check_eq("pre_rst_data", tx_data, exp);
      end
    end
    rst_n = 1'b0;
    tick();
    check_eq("mid_rst_start_en", 32'(tx_start_en), 32'd0);
    check_eq("mid_rst_byte_num", 32'(tx_byte_num), 32'd0);
    check_eq("mid_rst_tx_data",  tx_data,          32'd0);
    check_eq("mid_rst_ovf",      32'(ovf),         32'd0);
    check_eq("mid_rst_full",     32'(fifo_full),   32'd0);
    rst_n = 1'b1;
    mq.delete();
    m_seq   = '0;
    m_frame = '0;
    expect_no_start("post_rst_idle", 20);
    for (int unsigned i = 0; i < PKT; i++) write_word($urandom, 1'b0);
    run_packet(3, 1'b0);

    check_eq("start_gap", gap_viol, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
